// File: rtl/pwm_pkg.sv
// Shared types and default widths for the multichannel PWM peripheral.
package pwm_pkg;

  localparam int DEF_NUM_CH = 16;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_PRE_W  = 8;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Shared prescaled timebase: edge/center counter, period shadowing and boundary pulse.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             center_mode,
  input  logic [PRE_W-1:0] prescale,
  input  logic             period_wr,
  input  logic [CNT_W-1:0] period_data,
  output logic [CNT_W-1:0] cnt,
  output logic             boundary,
  output logic             period_tick
);

  logic [PRE_W-1:0] pre_cnt, pre_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] p_stg, p_act;
  dir_e             dir, dir_next;
  pwm_mode_e        mode_act;
  logic             tick;

  always_comb begin
    tick     = (pre_cnt == prescale);
    pre_next = (pre_cnt >= prescale) ? '0 : pre_cnt + 1'b1;
    cnt_next = cnt;
    dir_next = dir;
    if (tick) begin
      if (mode_act == MODE_EDGE) begin
        cnt_next = (cnt >= p_act) ? '0 : cnt + 1'b1;
        dir_next = DIR_UP;
      end else if (dir == DIR_UP) begin
        if (cnt >= p_act) begin
          // A zero period parks the counter at 0 instead of turning round.
          if (p_act == '0) begin
            cnt_next = '0;
          end else begin
            cnt_next = p_act - 1'b1;
            dir_next = DIR_DOWN;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end else begin
        cnt_next = (cnt == '0) ? '0 : cnt - 1'b1;
      end
    end
    boundary = tick && (cnt_next == '0);
    if (boundary) dir_next = DIR_UP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt     <= '0;
      cnt         <= '0;
      dir         <= DIR_UP;
      p_stg       <= '0;
      p_act       <= '0;
      mode_act    <= MODE_EDGE;
      period_tick <= 1'b0;
    end else begin
      pre_cnt     <= pre_next;
      cnt         <= cnt_next;
      dir         <= dir_next;
      period_tick <= boundary;
      if (boundary) begin
        p_act    <= p_stg;
        mode_act <= pwm_mode_e'(center_mode);
      end
      if (period_wr) p_stg <= period_data;
    end
  end

endmodule

// File: rtl/pwm_multichannel.sv
// NUM_CH PWM outputs from one shared timebase with double-buffered per-channel duty.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PRE_W  = DEF_PRE_W,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en_out,
  input  logic [NUM_CH-1:0] en_pwm,
  input  logic              center_mode,
  input  logic [PRE_W-1:0]  prescale,
  input  logic              period_wr,
  input  logic [CNT_W-1:0]  period_data,
  input  logic              duty_wr,
  input  logic [CH_W-1:0]   duty_ch,
  input  logic [CNT_W-1:0]  duty_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_tick
);

  logic [CNT_W-1:0] cnt;
  logic             boundary;

  pwm_timebase #(
    .CNT_W(CNT_W),
    .PRE_W(PRE_W)
  ) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .center_mode(center_mode),
    .prescale   (prescale),
    .period_wr  (period_wr),
    .period_data(period_data),
    .cnt        (cnt),
    .boundary   (boundary),
    .period_tick(period_tick)
  );

  // Channel selects beyond NUM_CH match no slice, so such writes are dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] duty_stg, duty_act;
    logic             out_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        duty_stg <= '0;
        duty_act <= '0;
        out_q    <= 1'b0;
      end else begin
        if (duty_wr && (duty_ch == CH_W'(g))) duty_stg <= duty_data;
        if (boundary) duty_act <= duty_stg;
        out_q <= en_out[g] & (~en_pwm[g] | (cnt < duty_act));
      end
    end

    assign out[g] = out_q;
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Randomized bench for pwm_multichannel against a period-phase reference model.
module tb_pwm_multichannel;

  localparam int NUM = 12;
  localparam int CW  = 8;
  localparam int PW  = 8;
  localparam int CHW = $clog2(NUM);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NUM-1:0] en_out = '0;
  logic [NUM-1:0] en_pwm = '0;
  logic           center_mode = 1'b0;
  logic [PW-1:0]  prescale = '0;
  logic           period_wr = 1'b0;
  logic [CW-1:0]  period_data = '0;
  logic           duty_wr = 1'b0;
  logic [CHW-1:0] duty_ch = '0;
  logic [CW-1:0]  duty_data = '0;
  logic [NUM-1:0] out;
  logic           period_tick;

  int checks = 0;
  int errors = 0;

  pwm_multichannel #(
    .NUM_CH(NUM),
    .CNT_W (CW),
    .PRE_W (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_out     (en_out),
    .en_pwm     (en_pwm),
    .center_mode(center_mode),
    .prescale   (prescale),
    .period_wr  (period_wr),
    .period_data(period_data),
    .duty_wr    (duty_wr),
    .duty_ch    (duty_ch),
    .duty_data  (duty_data),
    .out        (out),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  // Reference model: position k within the current period, period length from P and mode.
  int m_pre, m_k, m_p, m_len, m_mode, m_pstg;
  int dstg[NUM];
  int dact[NUM];
  logic [NUM-1:0] exp_out = '0;
  logic           exp_pt = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int len_of(input int p, input int mode);
    if (mode == 0) return p + 1;
    return (p == 0) ? 1 : 2 * p;
  endfunction

  function automatic int cur_cnt();
    if (m_mode == 0) return m_k;
    return (m_k <= m_p) ? m_k : 2 * m_p - m_k;
  endfunction

  task automatic model_edge();
    bit tick;
    if (rst) begin
      m_pre = 0; m_k = 0; m_p = 0; m_mode = 0; m_pstg = 0;
      m_len = len_of(0, 0);
      for (int i = 0; i < NUM; i++) begin dstg[i] = 0; dact[i] = 0; end
      exp_out = '0;
      exp_pt  = 1'b0;
      return;
    end
    for (int i = 0; i < NUM; i++)
      exp_out[i] = en_out[i] && (!en_pwm[i] || (cur_cnt() < dact[i]));
    tick  = (m_pre == int'(prescale));
    m_pre = (m_pre >= int'(prescale)) ? 0 : m_pre + 1;
    exp_pt = 1'b0;
    if (tick) begin
      m_k = (m_k + 1) % m_len;
      if (m_k == 0) begin
        exp_pt = 1'b1;
        m_p    = m_pstg;
        m_mode = int'(center_mode);
        m_len  = len_of(m_p, m_mode);
        for (int i = 0; i < NUM; i++) dact[i] = dstg[i];
      end
    end
    if (period_wr) m_pstg = int'(period_data);
    if (duty_wr && int'(duty_ch) < NUM) dstg[duty_ch] = int'(duty_data);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("out", 32'(out), 32'(exp_out));
    check_eq("period_tick", 32'(period_tick), 32'(exp_pt));
  endtask

  task automatic wr_period(input int p);
    period_wr = 1'b1; period_data = CW'(p);
    step();
    period_wr = 1'b0;
  endtask

  task automatic wr_duty(input int ch, input int d);
    duty_wr = 1'b1; duty_ch = CHW'(ch); duty_data = CW'(d);
    step();
    duty_wr = 1'b0;
  endtask

  task automatic wait_ptick();
    int n = 0;
    step();
    while (!period_tick && n < 2000) begin step(); n++; end
    if (n >= 2000) check_eq("ptick_timeout", 32'd0, 32'd1);
  endtask

  // Counts out[ch] and period_tick over the n samples following the current one.
  task automatic count_hi(input int ch, input int n, output int hi, output int pt);
    hi = 0; pt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      hi += int'(out[ch]);
      pt += int'(period_tick);
    end
  endtask

  initial begin
    int h, p, h2, h3;

    step(); step();
    check_eq("reset_out", 32'(out), 32'd0);
    check_eq("reset_ptick", 32'(period_tick), 32'd0);
    rst = 1'b0;
    en_out = '1; en_pwm = '1;

    // Edge mode, P=9, duty0=3
    wr_period(9);
    wr_duty(0, 3);
    wait_ptick(); wait_ptick();
    count_hi(0, 10, h, p);
    check_eq("edge_high", 32'(h), 32'd3);
    check_eq("edge_ptick", 32'(p), 32'd1);

    // Center mode, P=4, duty2=2, prescale=1
    center_mode = 1'b1; prescale = 8'd1;
    wr_period(4);
    wr_duty(2, 2);
    wait_ptick(); wait_ptick(); wait_ptick();
    count_hi(2, 16, h, p);
    check_eq("center_high", 32'(h), 32'd6);
    check_eq("center_ptick", 32'(p), 32'd1);

    // Extremes and enables, edge P=9
    center_mode = 1'b0; prescale = 8'd0;
    wr_period(9);
    wr_duty(0, 0);
    wr_duty(1, 255);
    wr_duty(4, 5);
    en_pwm[3] = 1'b0; en_out[4] = 1'b0;
    wait_ptick(); wait_ptick(); wait_ptick();
    count_hi(0, 20, h, p); check_eq("duty0_const0", 32'(h), 32'd0);
    count_hi(1, 20, h, p); check_eq("duty255_const1", 32'(h), 32'd20);
    count_hi(3, 20, h, p); check_eq("en_pwm0_const1", 32'(h), 32'd20);
    count_hi(4, 20, h, p); check_eq("en_out0_const0", 32'(h), 32'd0);

    // Out-of-range channel select leaves every channel untouched
    wr_duty(13, 7);
    wait_ptick(); wait_ptick();
    count_hi(0, 10, h, p); check_eq("oor_ch0", 32'(h), 32'd0);
    count_hi(1, 10, h, p); check_eq("oor_ch1", 32'(h), 32'd10);

    // Mid-period write keeps the old duty until the next boundary
    wait_ptick();
    count_hi(1, 3, h, p);
    duty_wr = 1'b1; duty_ch = CHW'(1); duty_data = 8'd8;
    count_hi(1, 1, h2, p);
    duty_wr = 1'b0;
    count_hi(1, 6, h3, p);
    check_eq("shadow_old", 32'(h + h2 + h3), 32'd10);
    count_hi(1, 10, h, p); check_eq("shadow_new", 32'(h), 32'd8);

    // Write on the boundary cycle applies one period later
    count_hi(1, 9, h, p);
    duty_wr = 1'b1; duty_ch = CHW'(1); duty_data = 8'd2;
    count_hi(1, 1, h2, p);
    duty_wr = 1'b0;
    check_eq("bnd_wr_cur", 32'(h + h2), 32'd8);
    count_hi(1, 10, h, p); check_eq("bnd_wr_next", 32'(h), 32'd8);
    count_hi(1, 10, h, p); check_eq("bnd_wr_late", 32'(h), 32'd2);

    // Reset mid-period with outputs high
    count_hi(3, 4, h, p);
    rst = 1'b1;
    step(); step();
    check_eq("midrst_out", 32'(out), 32'd0);
    check_eq("midrst_ptick", 32'(period_tick), 32'd0);
    rst = 1'b0;
    step();
    check_eq("midrst_first_ptick", 32'(period_tick), 32'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      period_wr   = ($urandom_range(0, 15) == 0);
      period_data = CW'($urandom_range(0, 15));
      duty_wr     = ($urandom_range(0, 3) == 0);
      duty_ch     = CHW'($urandom_range(0, 15));
      duty_data   = ($urandom_range(0, 9) == 0) ? 8'd255 : CW'($urandom_range(0, 17));
      if ($urandom_range(0, 199) == 0) center_mode = ~center_mode;
      if ($urandom_range(0, 99) == 0) prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) en_out = NUM'($urandom);
      if ($urandom_range(0, 99) == 0) en_pwm = NUM'($urandom);
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0; period_wr = 1'b0; duty_wr = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
